// File: rtl/sipo_rx_pkg.sv
// Shared types and default sizing for the LSB-first serial receiver.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        PAR
    } state_e;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_FCNT_W = 8;
    localparam int CNT_W      = $clog2(DEF_WIDTH + 1);

    // Bit-counter width able to hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit-slot counter for the receiver: clear, load-1 on a frame start,
// increment per accepted bit, terminal count when the last data bit is due.
module sipo_bit_counter
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load1,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load1) begin
            count <= CW'(1);
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_lsb_rx.sv
// Serial-in/parallel-out receiver, LSB first, start strobe on bit 0.
// Define SIPO_LSB_RX_PARITY_EN to add a trailing even-parity slot and perr.
module sipo_lsb_rx
    import sipo_rx_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FCNT_W = DEF_FCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              start,
    input  logic              inp,
    output logic [WIDTH-1:0]  out,
    output logic              valid,
    output logic              err,
    output logic              perr,
    output logic [FCNT_W-1:0] frames
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state, state_nxt;
    logic             tc;
    logic             cnt_clr, cnt_load1, cnt_inc;
    logic             shift_en, word_done, abort;
    logic [WIDTH-1:0] shift_word;

    // Without the parity slot the word is taken straight off the shift path,
    // so only WIDTH-1 bits ever need storing.
`ifdef SIPO_LSB_RX_PARITY_EN
    logic [WIDTH-1:0] shreg;
    assign shift_word = {inp, shreg[WIDTH-1:1]};
`else
    logic [WIDTH-2:0] shreg;
    assign shift_word = {inp, shreg};
`endif

    sipo_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (enb && start) begin
                    shift_en  = 1'b1;
                    cnt_load1 = 1'b1;
                    state_nxt = RX;
                end
            end
            RX: begin
                if (enb) begin
                    shift_en = 1'b1;
                    if (start) begin
                        abort     = 1'b1;
                        cnt_load1 = 1'b1;
                    end else if (tc) begin
                        cnt_clr = 1'b1;
`ifdef SIPO_LSB_RX_PARITY_EN
                        state_nxt = PAR;
`else
                        word_done = 1'b1;
                        state_nxt = IDLE;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            PAR: begin
`ifdef SIPO_LSB_RX_PARITY_EN
                if (enb) begin
                    if (start) begin
                        abort     = 1'b1;
                        shift_en  = 1'b1;
                        cnt_load1 = 1'b1;
                        state_nxt = RX;
                    end else begin
                        word_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift register is reset along with the outputs; it is a few
    // flops, not a memory, so the reset costs nothing worth avoiding.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            out    <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
            perr   <= 1'b0;
            frames <= '0;
        end else begin
            valid <= word_done;
            err   <= abort;
`ifdef SIPO_LSB_RX_PARITY_EN
            perr <= word_done & ((^shreg) ^ inp);
            if (shift_en)  shreg <= shift_word;
            if (word_done) out   <= shreg;
`else
            perr <= 1'b0;
            if (shift_en)  shreg <= shift_word[WIDTH-1:1];
            if (word_done) out   <= shift_word;
`endif
            if (word_done) frames <= frames + FCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sipo_lsb_rx.sv
// Scoreboard bench for sipo_lsb_rx (WIDTH=4, FCNT_W=2); parity cases run
// only when SIPO_LSB_RX_PARITY_EN is defined.
module tb_sipo_lsb_rx;

    localparam int WIDTH  = 4;
    localparam int FCNT_W = 2;
`ifdef SIPO_LSB_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, enb, start, inp;
    logic [WIDTH-1:0]  out;
    logic              valid, err, perr;
    logic [FCNT_W-1:0] frames;

    always #5 clk = ~clk;

    sipo_lsb_rx #(.WIDTH(WIDTH), .FCNT_W(FCNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enb    (enb),
        .start  (start),
        .inp    (inp),
        .out    (out),
        .valid  (valid),
        .err    (err),
        .perr   (perr),
        .frames (frames)
    );

    typedef struct {
        int                slot;
        logic [WIDTH-1:0]  word;
        logic [FCNT_W-1:0] frames;
        logic              perr;
    } exp_t;

    exp_t vq[$];
    int   eq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   slot_no = 0;
    int   valid_seen = 0;
    int   err_seen   = 0;
    bit   mon_en = 1'b0;

    // Reference model: collects bits by index rather than by shifting.
    bit                m_in, m_par;
    int                m_n;
    logic [WIDTH-1:0]  m_word, m_out;
    logic [FCNT_W-1:0] m_frames;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (slot %0d)", tag, got, exp, slot_no);
        end
    endtask

    task automatic finish_word(input logic p);
        exp_t e;
        m_in  = 1'b0;
        m_par = 1'b0;
        m_out = m_word;
        m_frames++;
        e.slot   = slot_no;
        e.word   = m_word;
        e.frames = m_frames;
        e.perr   = p;
        vq.push_back(e);
    endtask

    // One clock slot: drive inputs, take the edge, advance the model.
    task automatic tick(input logic r, input logic e, input logic s, input logic d);
        rst = r; enb = e; start = s; inp = d;
        @(posedge clk);
        slot_no++;
        if (r) begin
            m_in = 1'b0; m_par = 1'b0; m_n = 0;
            m_out = '0; m_frames = '0;
        end else if (e) begin
            if (s) begin
                if (m_in) eq.push_back(slot_no);
                m_in = 1'b1; m_par = 1'b0;
                m_word = '0; m_word[0] = d; m_n = 1;
            end else if (m_in) begin
                if (m_par) begin
                    finish_word((^m_word) ^ d);
                end else begin
                    m_word[m_n] = d;
                    m_n++;
                    if (m_n == WIDTH) begin
                        if (PAR_EN) m_par = 1'b1;
                        else        finish_word(1'b0);
                    end
                end
            end
        end
        #1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic pbit);
        for (int i = 0; i < WIDTH; i++) tick(1'b0, 1'b1, (i == 0), w[i]);
        if (PAR_EN) tick(1'b0, 1'b1, 1'b0, pbit);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("valid_err_excl", 32'(valid & err), 32'd0);
            if (valid) begin
                valid_seen++;
                if (vq.size() == 0) begin
                    check("valid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = vq.pop_front();
                    check("valid_slot", slot_no, e.slot);
                    check("out", 32'(out), 32'(e.word));
                    check("frames", 32'(frames), 32'(e.frames));
                    check("perr", 32'(perr), 32'(e.perr));
                end
            end else if (vq.size() != 0 && vq[0].slot <= slot_no) begin
                check("valid_missing", 32'd0, 32'd1);
                void'(vq.pop_front());
            end
            if (err) begin
                err_seen++;
                if (eq.size() == 0) check("err_unexpected", 32'd1, 32'd0);
                else check("err_slot", slot_no, eq.pop_front());
            end else if (eq.size() != 0 && eq[0] <= slot_no) begin
                check("err_missing", 32'd0, 32'd1);
                void'(eq.pop_front());
            end
            check("out_held", 32'(out), 32'(m_out));
            check("frames_held", 32'(frames), 32'(m_frames));
            if (!PAR_EN) check("perr_tied", 32'(perr), 32'd0);
        end
    end

    initial begin
        int v0, e0;
        rst = 1'b1; enb = 1'b0; start = 1'b0; inp = 1'b0;

        // Reset held three cycles, then toggling data without start.
        do_reset();
        mon_en = 1'b1;
        do_reset();
        do_reset();
        check("rst_out", 32'(out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frames", 32'(frames), 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, logic'(i % 2));
        check("idle_out", 32'(out), 32'd0);
        check("idle_frames", 32'(frames), 32'd0);

        // Single frame 4'hB.
        v0 = valid_seen;
        send_frame(4'hB, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("single_out", 32'(out), 32'hB);
        check("single_frames", 32'(frames), 32'd1);
        check("single_valid_cnt", valid_seen - v0, 32'd1);

        // Gapped enable between bits 2 and 3; start is ignored while enb=0.
        do_reset();
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        if (PAR_EN) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("gap_out", 32'(out), 32'hB);
        check("gap_frames", 32'(frames), 32'd1);

        // Early start mid-frame.
        do_reset();
        e0 = err_seen;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        if (PAR_EN) tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("early_out", 32'(out), 32'h9);
        check("early_frames", 32'(frames), 32'd1);
        check("early_err_cnt", err_seen - e0, 32'd1);

        // Early start landing in the last data-bit slot.
        do_reset();
        e0 = err_seen;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(4'h6, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("last_slot_out", 32'(out), 32'h6);
        check("last_slot_err_cnt", err_seen - e0, 32'd1);

        // Back-to-back frames with counter wrap, then reset mid-frame.
        do_reset();
        v0 = valid_seen;
        e0 = err_seen;
        for (int k = 1; k <= 5; k++) send_frame(4'(k), ^(4'(k)));
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b_valid_cnt", valid_seen - v0, 32'd5);
        check("b2b_err_cnt", err_seen - e0, 32'd0);
        check("b2b_frames", 32'(frames), 32'd1);
        check("b2b_out", 32'(out), 32'h5);
        v0 = valid_seen;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        do_reset();
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_frames", 32'(frames), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        check("midrst_no_valid", valid_seen - v0, 32'd0);

`ifdef SIPO_LSB_RX_PARITY_EN
        // Good and bad parity, then a start landing in the parity slot.
        do_reset();
        send_frame(4'hB, 1'b1);
        check("par_good_perr", 32'(perr), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(4'hB, 1'b0);
        check("par_bad_perr", 32'(perr), 32'd1);
        check("par_bad_valid", 32'(valid), 32'd1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        e0 = err_seen;
        for (int i = 0; i < WIDTH; i++) tick(1'b0, 1'b1, (i == 0), 1'b1);
        send_frame(4'h3, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        check("par_abort_err_cnt", err_seen - e0, 32'd1);
        check("par_abort_out", 32'(out), 32'h3);
`endif

        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("valid_queue_drained", vq.size(), 32'd0);
        check("err_queue_drained", eq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
